i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//   Parametrised I2C master controller: runs START, 7-bit address + R/W, then N data bytes, then STOP.
//   Multi-byte read/write with per-byte valid/ready handshakes, programmable bit rate, sticky NACK error.
//   Bus pins are open-drain enables; pad tri-states and pull-ups live at top level.
//   Sits between a register/sequencer front end and the board-level I2C pads.
// PARAMETERS
//   QTR_DIV   25  clk cycles per quarter SCL bit period (bit = 4*QTR_DIV cycles); must be >= 2
//   DATA_W    8   data byte width, shifted MSB first
//   LEN_W     4   width of cmd_len; transfer length = cmd_len+1 bytes (1..2**LEN_W)
// PORTS
//   clk        in   1        clock
//   rst        in   1        synchronous, active-low reset
//   cmd_valid  in   1        command request
//   cmd_ready  out  1        high in IDLE; command accepted on cmd_valid & cmd_ready
//   cmd_addr   in   7        slave address
//   cmd_rw     in   1        0 = write, 1 = read
//   cmd_len    in   LEN_W    byte count minus one
//   wr_data    in   DATA_W   next write byte
//   wr_valid   in   1        wr_data available
//   wr_ready   out  1        1-cycle pulse: wr_data consumed
//   rd_data    out  DATA_W   received byte, held until next rd_valid
//   rd_valid   out  1        1-cycle pulse per received byte
//   busy       out  1        high from command accept until done
//   done       out  1        1-cycle pulse when STOP completes
//   ack_error  out  1        sticky: slave NACKed; cleared on next command accept
//   scl_i      in   1        SCL line sense
//   sda_i      in   1        SDA line sense
//   scl_oe     out  1        1 = pull SCL low; 0 = release
//   sda_oe     out  1        1 = pull SDA low; 0 = release
// BEHAVIOUR
//   Reset
//   - scl_oe=sda_oe=0, bus released on the next edge.
//   - busy=done=rd_valid=wr_ready=ack_error=0, rd_data=0, state=IDLE, cmd_ready=0 during reset.
//   - Mid-transfer reset aborts with no STOP; the bus is simply released.
//   States
//   - IDLE -> START -> ADDR -> A_ACK -> (WRITE -> W_ACK)* or (READ -> M_ACK)* -> STOP -> IDLE.
//   Bit timing
//   - Quarters q0..q3, each QTR_DIV cycles.
//   - q0,q1: SCL low; SDA updated at the start of q0.
//   - q2,q3: SCL released; SDA sampled on the last cycle of q2.
//   - START: SDA low for 2 quarters with SCL released, then SCL low.
//   - STOP: SDA low with SCL low for 1 quarter; release SCL for 1 quarter; release SDA; hold for 2 quarters; then pulse done.
//   Address phase
//   - Shifts {cmd_addr, cmd_rw}, 8 bits, MSB first.
//   - A_ACK samples sda_i: 0 = ACK. On 1: set ack_error and go to STOP.
//   Write
//   - On entering WRITE, wr_ready pulses in the cycle wr_valid=1 and wr_data is latched.
//   - If wr_valid=0, SCL is held low (stall) until wr_valid=1; timing restarts at q0.
//   - W_ACK NACK: set ack_error, STOP, remaining bytes skipped.
//   Read
//   - SDA is released for 8 bits. rd_valid pulses 1 cycle after the 8th sample.
//   - M_ACK drives ACK (sda_oe=1) for all bytes except the last; NACK (release) on the last.
//   Counting
//   - The byte counter loads cmd_len and decrements after each ACK slot; the transfer ends after the slot where the counter is 0.
//   - No wrap: cmd_len = all-ones gives 2**LEN_W bytes.
//   - cmd_valid while busy is ignored (cmd_ready=0).
//   - ack_error clears in the same cycle a new command is accepted.
// CONFIGURATION
//   I2C_CLK_STRETCH_EN
//   - Defined: after releasing SCL (q2 entry, STOP SCL release), the quarter counter holds until scl_i=1, so slave clock stretching is honoured.
//   - Undefined: scl_i is ignored and timing is purely counter-driven.
// TESTING
//   1. Write addr 0x50, cmd_len=0, data 0xA5, slave ACKs
//      -> SDA bytes 0xA0, 0xA5; one wr_ready; done; ack_error=0; bit period 100 clk.
//   2. Address 0x3C, slave NACK
//      -> ack_error=1; no wr_ready; STOP issued; done pulse; busy=0 after.
//   3. Read 3 bytes from 0x68, slave returns 0x11, 0x22, 0x33
//      -> rd_valid x3 with those values; master ACK, ACK, NACK.
//   4. Write 2 bytes, wr_valid withheld 50 clk before byte 2
//      -> scl_oe=1 held the whole stall; byte 2 sent intact.
//   5. rst=0 during the 4th data bit
//      -> scl_oe=sda_oe=0, busy=0 next cycle; a new command then runs normally.
//   6. Macro defined, slave holds SCL low 200 clk on bit 3
//      -> high phase starts only after scl_i=1; without the macro, the period stays 100 clk.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// I2C master controller: START, 7-bit address + R/W, cmd_len+1 data bytes, STOP, open-drain enables.
// Optional macro I2C_CLK_STRETCH_EN: SCL-high quarters wait for scl_i=1 (slave clock stretching).
module i2c_master_ctrl #(
  parameter int QTR_DIV = 25,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_addr,
  input  logic              cmd_rw,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              ack_error,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic [3:0]        dbg_state
);
  // Handshakes: a command transfers on cmd_valid & cmd_ready; a write byte transfers in the cycle
  // wr_ready is high (only while wr_valid is high); rd_valid and done are pulses with no back-pressure.
  localparam int SH_W = (DATA_W > 8) ? DATA_W : 8;
  localparam int QW   = $clog2(QTR_DIV);
  localparam int BW   = $clog2(SH_W);
  localparam logic [QW-1:0] Q_LAST = QW'(QTR_DIV - 1);
  localparam logic [BW-1:0] A_LAST = BW'(7);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_A_ACK, S_WRITE, S_W_ACK, S_READ, S_M_ACK, S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic rw_q, rw_d, have_q, have_d, nack_q, nack_d;
  logic ack_err_q, ack_err_d, done_q, done_d, rd_valid_q, rd_valid_d;

  logic bit_slot, stall, hold, q_end, slot_end, sample, last_bit, accept;
  logic [DATA_W-1:0] rx_full;

  always_comb begin
    bit_slot = state_q inside {S_ADDR, S_A_ACK, S_WRITE, S_W_ACK, S_READ, S_M_ACK};
    stall    = (state_q == S_WRITE) && !have_q;
`ifdef I2C_CLK_STRETCH_EN
    hold = !scl_i && ((bit_slot && !stall && qtr_q == 2'd2) || (state_q == S_STOP && qtr_q == 2'd1));
`else
    hold = scl_i & 1'b0;
`endif
    q_end    = (qcnt_q == Q_LAST) && !hold;
    slot_end = q_end && (qtr_q == 2'd3);
    sample   = bit_slot && !stall && (qtr_q == 2'd2) && (qcnt_q == Q_LAST) && !hold;
    last_bit = (state_q == S_ADDR) ? (bit_q == A_LAST) : (bit_q == D_LAST);
    rx_full  = {rx_q, sda_i};

    scl_oe = (bit_slot && (stall || !qtr_q[1])) || (state_q == S_STOP && qtr_q == 2'd0);
    case (state_q)
      S_START:         sda_oe = 1'b1;
      S_ADDR, S_WRITE: sda_oe = !stall && !sh_q[SH_W-1];
      S_M_ACK:         sda_oe = (cnt_q != '0);
      S_STOP:          sda_oe = !qtr_q[1];
      default:         sda_oe = 1'b0;
    endcase

    cmd_ready = (state_q == S_IDLE) && rst;
    accept    = cmd_valid && cmd_ready;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    rd_valid  = rd_valid_q;
    rd_data   = rd_data_q;
    ack_error = ack_err_q && !accept;
    dbg_state = state_q;
  end

  always_comb begin
    state_d = state_q; qcnt_d = qcnt_q; qtr_d = qtr_q; bit_d = bit_q; cnt_d = cnt_q;
    sh_d = sh_q; rx_d = rx_q; rd_data_d = rd_data_q; rw_d = rw_q; have_d = have_q;
    nack_d = nack_q; ack_err_d = ack_err_q; done_d = 1'b0; rd_valid_d = 1'b0;
    wr_ready = 1'b0;

    if (state_q != S_IDLE && !stall) begin
      if (q_end) begin
        qcnt_d = '0;
        qtr_d  = qtr_q + 2'd1;
      end else if (!hold) begin
        qcnt_d = qcnt_q + QW'(1);
      end
    end

    case (state_q)
      S_IDLE: if (accept) begin
        state_d   = S_START;
        sh_d      = SH_W'({cmd_addr, cmd_rw}) << (SH_W - 8);
        rw_d      = cmd_rw;
        cnt_d     = cmd_len;
        ack_err_d = 1'b0;
        qcnt_d    = '0;
        qtr_d     = 2'd0;
        bit_d     = '0;
      end
      S_START: if (q_end && qtr_q == 2'd1) begin
        state_d = S_ADDR;
        qtr_d   = 2'd0;
      end
      S_STOP: if (slot_end) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        if (stall) begin
          // SCL stays low until a byte is offered; bit timing restarts at q0 after the fetch
          if (wr_valid) begin
            wr_ready = 1'b1;
            sh_d     = SH_W'(wr_data) << (SH_W - DATA_W);
            have_d   = 1'b1;
            qcnt_d   = '0;
            qtr_d    = 2'd0;
          end
        end else begin
          if (sample) begin
            if (state_q == S_A_ACK || state_q == S_W_ACK) begin
              nack_d    = sda_i;
              ack_err_d = ack_err_q | sda_i;
            end else if (state_q == S_READ) begin
              rx_d = rx_full[DATA_W-2:0];
              if (last_bit) begin
                rd_data_d  = rx_full;
                rd_valid_d = 1'b1;
              end
            end
          end
          if (slot_end) begin
            bit_d = bit_q + BW'(1);
            if (state_q == S_ADDR || state_q == S_WRITE) sh_d = sh_q << 1;
            case (state_q)
              S_ADDR:  if (last_bit) begin state_d = S_A_ACK; bit_d = '0; end
              S_WRITE: if (last_bit) begin state_d = S_W_ACK; bit_d = '0; end
              S_READ:  if (last_bit) begin state_d = S_M_ACK; bit_d = '0; end
              S_A_ACK: begin
                bit_d = '0;
                if (nack_q)    state_d = S_STOP;
                else if (rw_q) state_d = S_READ;
                else begin state_d = S_WRITE; have_d = 1'b0; end
              end
              S_W_ACK: begin
                bit_d = '0;
                if (nack_q || cnt_q == '0) state_d = S_STOP;
                else begin state_d = S_WRITE; have_d = 1'b0; cnt_d = cnt_q - LEN_W'(1); end
              end
              S_M_ACK: begin
                bit_d = '0;
                if (cnt_q == '0) state_d = S_STOP;
                else begin state_d = S_READ; cnt_d = cnt_q - LEN_W'(1); end
              end
              default: state_d = S_STOP;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE; qcnt_q <= '0; qtr_q <= 2'd0; bit_q <= '0; cnt_q <= '0;
      sh_q <= '0; rx_q <= '0; rd_data_q <= '0; rw_q <= 1'b0; have_q <= 1'b0;
      nack_q <= 1'b0; ack_err_q <= 1'b0; done_q <= 1'b0; rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d; qcnt_q <= qcnt_d; qtr_q <= qtr_d; bit_q <= bit_d; cnt_q <= cnt_d;
      sh_q <= sh_d; rx_q <= rx_d; rd_data_q <= rd_data_d; rw_q <= rw_d; have_q <= have_d;
      nack_q <= nack_d; ack_err_q <= ack_err_d; done_q <= done_d; rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: per-transaction cycle timeline model built from the bus rules,
// compared every cycle, plus a bus monitor decoding bits at SCL release for literal checks.
module tb_i2c_master_ctrl;
  localparam int Q = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0, cmd_rw = 1'b0, wr_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic       cmd_ready, wr_ready, rd_valid, busy, done, ack_error;
  logic [7:0] rd_data;
  logic       scl_i, sda_i, scl_oe, sda_oe;
  logic [3:0] dbg_state;
  logic       spull = 1'b0, shold = 1'b0;

  assign scl_i = !(scl_oe || shold);
  assign sda_i = !(sda_oe || spull);

  i2c_master_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .ack_error(ack_error),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: SDA line value at each SCL release, plus pulse counters
  logic mon_prev = 1'b0;
  logic mon_bits[$];
  int   mon_t[$];
  int   wrr_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (mon_prev && !scl_oe) begin
      mon_bits.push_back(sda_i);
      mon_t.push_back(cyc);
    end
    mon_prev = scl_oe;
    if (wr_ready) wrr_cnt++;
    if (done) done_cnt++;
  end

  task automatic mon_clear();
    mon_bits.delete(); mon_t.delete(); wrr_cnt = 0; done_cnt = 0;
  endtask

  function automatic logic [7:0] byte_at(int s);
    logic [7:0] b;
    b = 8'hxx;
    if (s + 8 <= mon_bits.size())
      for (int i = 0; i < 8; i++) b[7-i] = mon_bits[s+i];
    return b;
  endfunction

  function automatic int period_at(int k);
    if (k + 1 < mon_t.size()) return mon_t[k+1] - mon_t[k];
    return -1;
  endfunction

  // Timeline model: one entry per clock cycle starting at the command-accept cycle
  typedef struct packed {
    logic scl, sda, spull, wrv, wrr, rdv, done, busy, aerr;
    logic [7:0] rdd;
    logic [7:0] wrd;
  } cyc_t;

  cyc_t       tl[$];
  logic       m_aerr = 1'b0;
  logic [7:0] m_rdd = 8'h00;
  logic [7:0] cur_wrd = 8'h00;
  logic [7:0] bytes_v[4];
  int         stretch_at = -1;

  task automatic add(int n, logic scl, logic sda, logic sp, logic wrv, logic wrr, logic rdv1);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.scl = scl; c.sda = sda; c.spull = sp; c.wrv = wrv; c.wrr = wrr;
      c.rdv = rdv1 && (i == 0); c.busy = 1'b1; c.aerr = m_aerr; c.rdd = m_rdd; c.wrd = cur_wrd;
      tl.push_back(c);
    end
  endtask

  task automatic add_idle(logic dn);
    cyc_t c;
    c = '0;
    c.done = dn; c.aerr = m_aerr; c.rdd = m_rdd;
    tl.push_back(c);
  endtask

  // One bit slot: SCL low 2 quarters then released 2; a sampled NACK or read byte shows from q3
  task automatic add_bit(logic md, logic sp, logic set_nack, logic rd_last, logic [7:0] rb, logic stretch);
    int ext;
    ext = 0;
    if (stretch) begin
      stretch_at = tl.size();
`ifdef I2C_CLK_STRETCH_EN
      ext = 200 - 2 * Q;
`endif
    end
    add(2 * Q, 1'b1, md, sp, 1'b0, 1'b0, 1'b0);
    add(Q + ext, 1'b0, md, sp, 1'b0, 1'b0, 1'b0);
    if (set_nack) m_aerr = 1'b1;
    if (rd_last) m_rdd = rb;
    add(Q, 1'b0, md, sp, 1'b0, 1'b0, rd_last);
  endtask

  task automatic add_byte_out(logic [7:0] b, int stretch_bit);
    for (int i = 7; i >= 0; i--) add_bit(!b[i], 1'b0, 1'b0, 1'b0, 8'h00, (7 - i) == stretch_bit);
  endtask

  task automatic build(logic [6:0] addr, logic rw, int nbytes, logic addr_ack,
                       int stall_b, int stall_n, int stretch_bit);
    tl.delete();
    stretch_at = -1;
    cur_wrd = 8'h00;
    m_aerr = 1'b0;
    add_idle(1'b0);
    add(2 * Q, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_byte_out({addr, rw}, stretch_bit);
    add_bit(1'b0, addr_ack, !addr_ack, 1'b0, 8'h00, 1'b0);
    if (addr_ack) begin
      for (int k = 0; k < nbytes; k++) begin
        if (!rw) begin
          cur_wrd = bytes_v[k];
          add((k == stall_b) ? stall_n : 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          add(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
          add_byte_out(bytes_v[k], -1);
          add_bit(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end else begin
          for (int i = 7; i >= 0; i--)
            add_bit(1'b0, !bytes_v[k][i], 1'b0, i == 0, bytes_v[k], 1'b0);
          add_bit(k != nbytes - 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
      end
    end
    cur_wrd = 8'h00;
    add(Q, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(Q, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2 * Q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(1'b1);
    repeat (3) add_idle(1'b0);
  endtask

  // Drives the timeline into the DUT and compares every cycle; abort_at>=0 pulses rst there
  task automatic execute(logic [6:0] addr, logic rw, logic [3:0] len, int abort_at, logic hv);
    cyc_t c;
    for (int i = 0; i < tl.size(); i++) begin
      c = tl[i];
      @(posedge clk); #1;
      cmd_valid = (i == 0) || (hv && c.busy);
      cmd_addr = addr; cmd_rw = rw; cmd_len = len;
      wr_valid = c.wrv; wr_data = c.wrd; spull = c.spull;
      shold = (stretch_at >= 0) && (i >= stretch_at) && (i < stretch_at + 200);
      if (i == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; spull = 1'b0; shold = 1'b0;
        @(negedge clk);
        check("abort_release", {19'd0, scl_oe, sda_oe, busy, done, ack_error, rd_data}, 32'd0);
        m_aerr = 1'b0;
        m_rdd = 8'h00;
        break;
      end
      @(negedge clk);
      check($sformatf("cycle[%0d]", i),
            {16'd0, scl_oe, sda_oe, busy, done, wr_ready, rd_valid, ack_error, cmd_ready, rd_data},
            {16'd0, c.scl, c.sda, c.busy, c.done, c.wrr, c.rdv, c.aerr, !c.busy, c.rdd});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_valid = 1'b0; spull = 1'b0; shold = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {16'd0, scl_oe, sda_oe, busy, done, wr_ready, rd_valid, ack_error, cmd_ready, rd_data}, 32'd0);
    check("reset_state", {28'd0, dbg_state}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: single-byte write, slave ACKs
    mon_clear();
    bytes_v[0] = 8'hA5;
    build(7'h50, 1'b0, 1, 1'b1, -1, 0, -1);
    check("t1_model_len", tl.size(), 32'd1956);
    execute(7'h50, 1'b0, 4'd0, -1, 1'b0);
    check("t1_addr_byte", {24'd0, byte_at(0)}, 32'hA0);
    check("t1_data_byte", {24'd0, byte_at(9)}, 32'hA5);
    check("t1_wr_ready_cnt", wrr_cnt, 32'd1);
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_bit_period", period_at(0), 32'd100);
    check("t1_ack_error", {31'd0, ack_error}, 32'd0);

    // 2: address NACK
    mon_clear();
    bytes_v[0] = 8'h77;
    build(7'h3C, 1'b0, 1, 1'b0, -1, 0, -1);
    execute(7'h3C, 1'b0, 4'd0, -1, 1'b0);
    check("t2_addr_byte", {24'd0, byte_at(0)}, 32'h78);
    check("t2_nack_bit", (mon_bits.size() > 8) ? {31'd0, mon_bits[8]} : 32'hFFFF, 32'd1);
    check("t2_wr_ready_cnt", wrr_cnt, 32'd0);
    check("t2_done_cnt", done_cnt, 32'd1);
    check("t2_ack_error", {31'd0, ack_error}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // 3: three-byte read, cmd_valid held high while busy
    mon_clear();
    bytes_v[0] = 8'h11; bytes_v[1] = 8'h22; bytes_v[2] = 8'h33;
    build(7'h68, 1'b1, 3, 1'b1, -1, 0, -1);
    execute(7'h68, 1'b1, 4'd2, -1, 1'b1);
    check("t3_addr_byte", {24'd0, byte_at(0)}, 32'hD1);
    check("t3_rd0", {24'd0, byte_at(9)}, 32'h11);
    check("t3_rd2", {24'd0, byte_at(27)}, 32'h33);
    check("t3_mack_pattern",
          (mon_bits.size() > 35) ? {29'd0, mon_bits[17], mon_bits[26], mon_bits[35]} : 32'hFFFF, 32'd1);
    check("t3_rd_data_hold", {24'd0, rd_data}, 32'h33);
    check("t3_done_cnt", done_cnt, 32'd1);

    // 4: two-byte write, 50-cycle stall before byte 2
    mon_clear();
    bytes_v[0] = 8'h5A; bytes_v[1] = 8'hC3;
    build(7'h21, 1'b0, 2, 1'b1, 1, 50, -1);
    execute(7'h21, 1'b0, 4'd1, -1, 1'b0);
    check("t4_byte1", {24'd0, byte_at(9)}, 32'h5A);
    check("t4_byte2", {24'd0, byte_at(18)}, 32'hC3);
    check("t4_wr_ready_cnt", wrr_cnt, 32'd2);

    // 5: reset during the 4th data bit, then a normal one-byte read
    mon_clear();
    bytes_v[0] = 8'h99;
    build(7'h12, 1'b0, 1, 1'b1, -1, 0, -1);
    execute(7'h12, 1'b0, 4'd0, 1 + 2 * Q + 36 * Q + 1 + 12 * Q + 40, 1'b0);
    check("t5_no_done", done_cnt, 32'd0);
    mon_clear();
    bytes_v[0] = 8'hE7;
    build(7'h2D, 1'b1, 1, 1'b1, -1, 0, -1);
    execute(7'h2D, 1'b1, 4'd0, -1, 1'b0);
    check("t5_addr_byte", {24'd0, byte_at(0)}, 32'h5B);
    check("t5_rd_byte", {24'd0, rd_data}, 32'hE7);
    check("t5_last_nack", (mon_bits.size() > 17) ? {31'd0, mon_bits[17]} : 32'hFFFF, 32'd1);

    // 6: slave holds SCL low for 200 cycles from the start of address bit 3
    mon_clear();
    bytes_v[0] = 8'h3C;
    build(7'h50, 1'b0, 1, 1'b1, -1, 0, 3);
    execute(7'h50, 1'b0, 4'd0, -1, 1'b0);
`ifdef I2C_CLK_STRETCH_EN
    check("t6_stretched_period", period_at(3), 32'd250);
`else
    check("t6_plain_period", period_at(3), 32'd100);
`endif
    check("t6_data_byte", {24'd0, byte_at(9)}, 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
